// File: rtl/uart_sched_pkg.sv
// Shared types, default parameters and sizing helpers for the UART transmit scheduler.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_CLK_FREQ   = 50_000_000;
    localparam int DEF_BAUD_RATE  = 9600;
    localparam int DEF_GAP_CYCLES = 16;

    // Watchdog budget: 12 bit times, which leaves margin over a 10-bit 8N1 frame.
    function automatic int default_timeout(input longint clk_freq, input longint baud_rate);
        return int'((longint'(12) * clk_freq) / baud_rate);
    endfunction

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational pick from last_grant+1 upward with wrap,
// pointer advanced only when the pick is actually taken.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 accept,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 any_req
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] last_grant;
    logic [IW-1:0] cand;
    logic          found;

    assign any_req = |req;

    // Search the N positions following last_grant and take the first requester.
    always_comb begin
        found     = 1'b0;
        cand      = '0;
        grant_idx = '0;
        grant     = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IW'((int'(last_grant) + i) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Pointer starts at N-1 so requester 0 has first priority out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= IW'(N - 1);
        end else if (accept) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one uart_tx among NUM_REQ byte requesters with round-robin fairness,
// a per-frame watchdog and an enforced idle gap after every frame.
//
// state | meaning
// IDLE  | no frame in flight; arbitrate and accept one byte when any request is pending
// START | byte latched; start_tx pulse is registered out during the next cycle
// WAIT  | frame on the line; wait for a tx_done rising edge or watchdog expiry
// GAP   | mandatory inter-frame idle time before the next acceptance
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int CLK_FREQ       = DEF_CLK_FREQ,
    parameter int BAUD_RATE      = DEF_BAUD_RATE,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = default_timeout(CLK_FREQ, BAUD_RATE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       start_tx,
    output logic [7:0]                 data_tx,
    input  logic                       tx_done,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       timeout_err,
    input  logic                       clr_err
);

    localparam int GIW = $clog2(NUM_REQ);
    localparam int WDW = cnt_width(TIMEOUT_CYCLES);
    localparam int GPW = cnt_width(GAP_CYCLES);

    localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT_CYCLES - 1);
    // A zero gap still spends one cycle in GAP, so both 0 and 1 end on count 0.
    localparam logic [GPW-1:0] GAP_LAST = GPW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    state_t state;
    state_t state_nxt;

    logic [NUM_REQ-1:0] arb_grant;
    logic [GIW-1:0]     arb_idx;
    logic               any_req;
    logic               accept;
    logic               timeout_evt;
    logic               done_q;
    logic               done_rise;
    logic [WDW-1:0]     wd_cnt;
    logic [GPW-1:0]     gap_cnt;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .accept    (accept),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_req   (any_req)
    );

    // Edge detect runs in every state so a level already high entering WAIT is not a rise.
    assign done_rise = tx_done & ~done_q;
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the accept and watchdog-abort strobes.
    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        timeout_evt = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    accept    = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (done_rise) begin
                    state_nxt = GAP;
                end else if (wd_cnt == WD_LAST) begin
                    timeout_evt = 1'b1;
                    state_nxt   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered handshake and transmitter outputs; byte and owner hold until the next accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_ready <= '0;
            start_tx  <= 1'b0;
            data_tx   <= 8'h00;
            grant_id  <= '0;
        end else begin
            req_ready <= accept ? arb_grant : '0;
            start_tx  <= (state == START);
            if (accept) begin
                data_tx  <= req_data[{arb_idx, 3'b000} +: 8];
                grant_id <= arb_idx;
            end
        end
    end

    // Watchdog restarts in START and counts every WAIT cycle; gap counter runs only in GAP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt  <= '0;
            gap_cnt <= '0;
        end else begin
            if (state == START) begin
                wd_cnt <= '0;
            end else if (state == WAIT) begin
                wd_cnt <= wd_cnt + WDW'(1);
            end
            if (state == GAP) begin
                gap_cnt <= gap_cnt + GPW'(1);
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    // tx_done history for the edge detect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= tx_done;
        end
    end

    // Sticky abort flag; a new abort beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_err <= 1'b0;
        end else if (timeout_evt) begin
            timeout_err <= 1'b1;
        end else if (clr_err) begin
            timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a grant/data scoreboard.
module tb_uart_tx_sched;

    localparam int NREQ   = 4;
    localparam int TB_GAP = 16;
    localparam int TB_TO  = 400;
    localparam int DLY    = 50;
    localparam int BOUND  = 2000;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              start_tx;
    logic [7:0]        data_tx;
    logic              tx_done;
    logic              busy;
    logic [1:0]        grant_id;
    logic              timeout_err;
    logic              clr_err;

    exp_t sb[$];
    exp_t mon_e;
    int   total       = 0;
    int   passed      = 0;
    int   pushed      = 0;
    int   ready_count = 0;
    int   bad         = 0;

    always #5 clk = ~clk;

    uart_tx_sched #(
        .NUM_REQ        (NREQ),
        .CLK_FREQ       (50_000_000),
        .BAUD_RATE      (9600),
        .GAP_CYCLES     (TB_GAP),
        .TIMEOUT_CYCLES (TB_TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .start_tx    (start_tx),
        .data_tx     (data_tx),
        .tx_done     (tx_done),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err),
        .clr_err     (clr_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input int id, input logic [7:0] b);
        exp_t e;
        e.id   = id[1:0];
        e.data = b;
        sb.push_back(e);
        pushed++;
    endtask

    task automatic set_byte(input int i, input logic [7:0] b);
        req_data[8*i +: 8] = b;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (start_tx !== 1'b1 && n < BOUND) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 32'(start_tx), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < BOUND) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    // Pulse tx_done, then confirm busy drops exactly GAP+1 cycles after the pulse cycle.
    task automatic frame_done(input string tag);
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
        repeat (TB_GAP - 1) @(posedge clk);
        #1;
        check({tag, "_gap_busy"}, 32'(busy), 32'd1);
        @(posedge clk); #1;
        check({tag, "_gap_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic serve(input string tag);
        repeat (DLY) @(posedge clk);
        #1;
        frame_done(tag);
    endtask

    // Scoreboard: each req_ready must match the next expected grant; each start_tx pops it.
    always @(negedge clk) begin
        if (req_ready !== '0) begin
            ready_count++;
            if (sb.size() == 0) check("ready_unexpected", 32'(req_ready), 32'd0);
            else check("ready_onehot", 32'(req_ready), 32'd1 << sb[0].id);
        end
        if (start_tx === 1'b1) begin
            if (sb.size() == 0) begin
                check("start_unexpected", 32'(start_tx), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_data_tx", 32'(data_tx), 32'(mon_e.data));
                check("sb_grant_id", 32'(grant_id), 32'(mon_e.id));
            end
        end
    end

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_data  = '0;
        tx_done   = 1'b0;
        clr_err   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(start_tx), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_data", 32'(data_tx), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_err", 32'(timeout_err), 32'd0);
        rst = 1'b1;

        repeat (100) begin
            @(negedge clk);
            if (busy || start_tx || (req_ready != '0) || (data_tx != 8'h00) || (grant_id != 2'd0) || timeout_err)
                bad++;
        end
        check("idle_quiet", 32'(bad), 32'd0);

        // single byte with latency checks
        @(posedge clk); #1;
        set_byte(0, 8'h55);
        push(0, 8'h55);
        req_valid = 4'b0001;
        @(posedge clk); #1;
        check("lat_ready", 32'(req_ready), 32'd1);
        check("lat_busy", 32'(busy), 32'd1);
        req_valid = '0;
        @(posedge clk); #1;
        check("lat_start", 32'(start_tx), 32'd1);
        check("lat_data", 32'(data_tx), 32'h55);
        check("lat_ready_gone", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check("start_one_cycle", 32'(start_tx), 32'd0);
        serve("single");

        // round robin from a fresh pointer: 0,1,2,3,0
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) set_byte(i, 8'hA0 + 8'(i));
        push(0, 8'hA0); push(1, 8'hA1); push(2, 8'hA2); push(3, 8'hA3); push(0, 8'hA0);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_start("rr_start");
            if (k == 4) req_valid = '0;
            serve("rr");
        end
        check("rr_ready_count", 32'(ready_count), 32'(pushed));

        // fairness after wrap: pointer at 2, requests 0 and 2
        set_byte(2, 8'hC2);
        push(2, 8'hC2);
        req_valid = 4'b0100;
        wait_start("fair_setup_start");
        req_valid = '0;
        serve("fair_setup");
        set_byte(0, 8'hB0);
        set_byte(2, 8'hB2);
        push(0, 8'hB0); push(2, 8'hB2);
        req_valid = 4'b0101;
        wait_start("fair_start0");
        check("fair_grant0", 32'(grant_id), 32'd0);
        serve("fair0");
        wait_start("fair_start2");
        check("fair_grant2", 32'(grant_id), 32'd2);
        req_valid = '0;
        serve("fair2");

        // stale tx_done level plus a request withdrawn before it could be granted
        tx_done = 1'b1;
        set_byte(1, 8'h3C);
        push(1, 8'h3C);
        req_valid = 4'b0010;
        wait_start("stale_start");
        req_valid = '0;
        repeat (10) @(posedge clk);
        #1;
        req_valid = 4'b1000;
        repeat (10) @(posedge clk);
        #1;
        req_valid = '0;
        repeat (10) @(posedge clk);
        #1;
        check("stale_busy", 32'(busy), 32'd1);
        tx_done = 1'b0;
        @(posedge clk); #1;
        frame_done("stale");
        repeat (20) @(posedge clk);
        #1;
        check("withdrawn_no_grant", 32'(ready_count), 32'(pushed));

        // watchdog abort after exactly TB_TO WAIT cycles, then clear
        set_byte(0, 8'h77);
        push(0, 8'h77);
        req_valid = 4'b0001;
        wait_start("wd_start");
        req_valid = '0;
        repeat (TB_TO - 1) @(posedge clk);
        #1;
        check("wd_not_yet", 32'(timeout_err), 32'd0);
        check("wd_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("wd_set", 32'(timeout_err), 32'd1);
        wait_idle("wd_idle");
        check("wd_sticky", 32'(timeout_err), 32'd1);
        check("wd_no_retry", 32'(ready_count), 32'(pushed));
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        check("wd_clear", 32'(timeout_err), 32'd0);

        // clear coinciding with the abort cycle: set wins
        set_byte(0, 8'h78);
        push(0, 8'h78);
        req_valid = 4'b0001;
        wait_start("wd2_start");
        req_valid = '0;
        repeat (TB_TO - 1) @(posedge clk);
        #1;
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        check("wd_set_wins", 32'(timeout_err), 32'd1);
        wait_idle("wd2_idle");

        // asynchronous reset in the middle of WAIT
        set_byte(2, 8'h99);
        push(2, 8'h99);
        req_valid = 4'b0100;
        wait_start("arst_start");
        req_valid = '0;
        repeat (5) @(posedge clk);
        #1;
        check("arst_pre_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_data", 32'(data_tx), 32'd0);
        check("arst_grant", 32'(grant_id), 32'd0);
        check("arst_err", 32'(timeout_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // priority restarts at requester 0 after reset
        set_byte(0, 8'hE0);
        set_byte(3, 8'hE3);
        push(0, 8'hE0); push(3, 8'hE3);
        req_valid = 4'b1001;
        wait_start("post_start0");
        serve("post0");
        wait_start("post_start3");
        req_valid = '0;
        serve("post3");
        wait_idle("final_idle");
        check("final_ready_count", 32'(ready_count), 32'(pushed));
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
